// File: rtl/tawas_rcn_stall_ctl.sv
// Per-slice RCN outstanding-transaction tracker with shared credit pool and fence waits.
// Produces the registered per-slice rcn_stall vector consumed by instruction fetch.
module tawas_rcn_stall_ctl #(
    parameter int MAX_OUT = 3,
    parameter int CREDITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_vld,
    input  logic [1:0]  req_slice,
    input  logic        rsp_vld,
    input  logic [1:0]  rsp_slice,
    input  logic        fence_vld,
    input  logic [1:0]  fence_slice,
    output logic [3:0]  rcn_stall,
    output logic [11:0] out_cnt,
    output logic [3:0]  credits,
    output logic        err
);

    typedef enum logic {
        F_IDLE = 1'b0,
        F_WAIT = 1'b1
    } fence_t;

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUT);
    localparam logic [3:0] MAX_CRED = 4'(CREDITS);

    fence_t     fence_st [4];
    fence_t     fence_nx [4];
    logic [2:0] cnt      [4];
    logic [2:0] cnt_nx   [4];
    logic [3:0] cred_nx;
    logic [3:0] stall_nx;
    logic       err_nx;

    always_comb begin
        err_nx  = err;
        cred_nx = credits;
        if (req_vld && credits == 4'd0) err_nx = 1'b1;
        if (rsp_vld && credits == MAX_CRED) err_nx = 1'b1;
        // A req and a rsp in the same cycle cancel, whichever slices they belong to.
        if (req_vld && !rsp_vld && credits != 4'd0) cred_nx = credits - 4'd1;
        if (rsp_vld && !req_vld && credits != MAX_CRED) cred_nx = credits + 4'd1;

        for (int n = 0; n < 4; n++) begin
            cnt_nx[n]   = cnt[n];
            fence_nx[n] = fence_st[n];
            stall_nx[n] = 1'b0;

            if (req_vld && req_slice == 2'(n) && cnt[n] == MAX_CNT) err_nx = 1'b1;
            if (rsp_vld && rsp_slice == 2'(n) && cnt[n] == 3'd0) err_nx = 1'b1;

            if ((req_vld && req_slice == 2'(n)) && !(rsp_vld && rsp_slice == 2'(n))
                && cnt[n] != 3'd7)
                cnt_nx[n] = cnt[n] + 3'd1;
            if ((rsp_vld && rsp_slice == 2'(n)) && !(req_vld && req_slice == 2'(n))
                && cnt[n] != 3'd0)
                cnt_nx[n] = cnt[n] - 3'd1;

            case (fence_st[n])
                F_IDLE:  if (fence_vld && fence_slice == 2'(n) && cnt_nx[n] != 3'd0)
                             fence_nx[n] = F_WAIT;
                F_WAIT:  if (cnt_nx[n] == 3'd0)
                             fence_nx[n] = F_IDLE;
                default: fence_nx[n] = F_IDLE;
            endcase

            stall_nx[n] = (cnt_nx[n] >= MAX_CNT) || (fence_nx[n] == F_WAIT)
                          || (cred_nx == 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                cnt[n]      <= 3'd0;
                fence_st[n] <= F_IDLE;
            end
            credits   <= MAX_CRED;
            rcn_stall <= 4'h0;
            err       <= 1'b0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                cnt[n]      <= cnt_nx[n];
                fence_st[n] <= fence_nx[n];
            end
            credits   <= cred_nx;
            rcn_stall <= stall_nx;
            err       <= err_nx;
        end
    end

    assign out_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};

endmodule

// File: tb/tb_tawas_rcn_stall_ctl.sv
// Directed and randomized bench for tawas_rcn_stall_ctl against a rule-level
// model of outstanding counts, credits, fences and the sticky error flag.
module tb_tawas_rcn_stall_ctl;

    localparam int MAX_OUT = 3;
    localparam int CREDITS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_vld = 1'b0;
    logic [1:0]  req_slice = 2'd0;
    logic        rsp_vld = 1'b0;
    logic [1:0]  rsp_slice = 2'd0;
    logic        fence_vld = 1'b0;
    logic [1:0]  fence_slice = 2'd0;
    logic [3:0]  rcn_stall;
    logic [11:0] out_cnt;
    logic [3:0]  credits;
    logic        err;

    int total = 0;
    int bad   = 0;

    int m_cnt [4];
    int m_cred;
    bit m_fen [4];
    bit m_err;

    always #5 clk = ~clk;

    tawas_rcn_stall_ctl #(.MAX_OUT(MAX_OUT), .CREDITS(CREDITS)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld     (req_vld),
        .req_slice   (req_slice),
        .rsp_vld     (rsp_vld),
        .rsp_slice   (rsp_slice),
        .fence_vld   (fence_vld),
        .fence_slice (fence_slice),
        .rcn_stall   (rcn_stall),
        .out_cnt     (out_cnt),
        .credits     (credits),
        .err         (err)
    );

    function automatic void model_reset();
        for (int n = 0; n < 4; n++) begin
            m_cnt[n] = 0;
            m_fen[n] = 1'b0;
        end
        m_cred = CREDITS;
        m_err  = 1'b0;
    endfunction

    function automatic void model_step(bit r, bit q, int qs, bit p, int ps, bit f, int fs);
        if (r) begin
            model_reset();
            return;
        end
        if (q && m_cnt[qs] == MAX_OUT) m_err = 1'b1;
        if (q && m_cred == 0)          m_err = 1'b1;
        if (p && m_cnt[ps] == 0)       m_err = 1'b1;
        if (p && m_cred == CREDITS)    m_err = 1'b1;
        if (q && !p) m_cred = (m_cred > 0) ? m_cred - 1 : 0;
        if (p && !q) m_cred = (m_cred < CREDITS) ? m_cred + 1 : CREDITS;
        for (int n = 0; n < 4; n++) begin
            int v;
            v = m_cnt[n] + ((q && qs == n) ? 1 : 0) - ((p && ps == n) ? 1 : 0);
            m_cnt[n] = (v < 0) ? 0 : ((v > 7) ? 7 : v);
            if (m_fen[n]) begin
                if (m_cnt[n] == 0) m_fen[n] = 1'b0;
            end else if (f && fs == n && m_cnt[n] != 0) begin
                m_fen[n] = 1'b1;
            end
        end
    endfunction

    function automatic logic [3:0] exp_stall();
        logic [3:0] s;
        for (int n = 0; n < 4; n++)
            s[n] = (m_cnt[n] >= MAX_OUT) || m_fen[n] || (m_cred == 0);
        return s;
    endfunction

    function automatic logic [11:0] exp_cnt();
        return {3'(m_cnt[3]), 3'(m_cnt[2]), 3'(m_cnt[1]), 3'(m_cnt[0])};
    endfunction

    task automatic chk(string tag, logic [11:0] got, logic [11:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".stall"},   {8'h0, rcn_stall}, {8'h0, exp_stall()});
        chk({tag, ".cnt"},     out_cnt,           exp_cnt());
        chk({tag, ".credits"}, {8'h0, credits},   {8'h0, 4'(m_cred)});
        chk({tag, ".err"},     {11'h0, err},      {11'h0, m_err});
    endtask

    task automatic cyc(string tag, bit r, bit q, int qs, bit p, int ps, bit f, int fs);
        rst         = r;
        req_vld     = q;
        req_slice   = 2'(qs);
        rsp_vld     = p;
        rsp_slice   = 2'(ps);
        fence_vld   = f;
        fence_slice = 2'(fs);
        @(posedge clk);
        model_step(r, q, qs, p, ps, f, fs);
        #1;
        check_all(tag);
    endtask

    task automatic idle(string tag, int n);
        for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc("rst", 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit         q, p, f;
        int         qs, ps, fs;
        logic [3:0] st;
        bit         fence_seen;

        model_reset();
        do_reset();
        do_reset();
        idle("idle", 8);
        chk("reset_stall", {8'h0, rcn_stall}, 12'h000);
        chk("reset_cred",  {8'h0, credits},   12'h004);

        // three requests from slice 1 hit the per-slice limit
        cyc("s1_req0", 0, 1, 1, 0, 0, 0, 0);
        cyc("s1_req1", 0, 1, 1, 0, 0, 0, 0);
        cyc("s1_req2", 0, 1, 1, 0, 0, 0, 0);
        chk("s1_limit_stall", {8'h0, rcn_stall}, 12'h002);
        chk("s1_limit_cnt",   out_cnt,           12'h018);
        chk("s1_limit_cred",  {8'h0, credits},   12'h001);
        cyc("s1_rsp", 0, 0, 0, 1, 1, 0, 0);
        chk("s1_rsp_stall", {8'h0, rcn_stall}, 12'h000);
        chk("s1_rsp_cnt",   out_cnt,           12'h010);

        // credit exhaustion stalls everyone
        do_reset();
        for (int n = 0; n < 4; n++) cyc("all_req", 0, 1, n, 0, 0, 0, 0);
        chk("cred0_stall", {8'h0, rcn_stall}, 12'h00F);
        chk("cred0_cred",  {8'h0, credits},   12'h000);
        cyc("cred_rsp2", 0, 0, 0, 1, 2, 0, 0);
        chk("cred1_stall", {8'h0, rcn_stall}, 12'h000);
        chk("cred1_cred",  {8'h0, credits},   12'h001);

        // fence on slice 3 holds until its count drains
        do_reset();
        cyc("f3_req", 0, 1, 3, 0, 0, 0, 0);
        cyc("f3_req", 0, 1, 3, 0, 0, 0, 0);
        cyc("f3_fence", 0, 0, 0, 0, 0, 1, 3);
        chk("f3_wait", {11'h0, rcn_stall[3]}, 12'h001);
        idle("f3_hold", 2);
        cyc("f3_rsp", 0, 0, 0, 1, 3, 0, 0);
        chk("f3_still", {11'h0, rcn_stall[3]}, 12'h001);
        cyc("f3_rsp", 0, 0, 0, 1, 3, 0, 0);
        chk("f3_release", {8'h0, rcn_stall}, 12'h000);
        fence_seen = 1'b0;
        cyc("f0_fence", 0, 0, 0, 0, 0, 1, 0);
        fence_seen |= rcn_stall[0];
        idle("f0_idle", 3);
        fence_seen |= rcn_stall[0];
        chk("f0_nostall", {11'h0, fence_seen}, 12'h000);

        // simultaneous req/rsp
        do_reset();
        cyc("sim_req0", 0, 1, 0, 0, 0, 0, 0);
        cyc("sim_req0", 0, 1, 0, 0, 0, 0, 0);
        cyc("sim_req2", 0, 1, 2, 0, 0, 0, 0);
        cyc("sim_same", 0, 1, 0, 1, 0, 0, 0);
        chk("sim_same_cnt",  out_cnt,         12'h042);
        chk("sim_same_cred", {8'h0, credits}, 12'h001);
        chk("sim_same_err",  {11'h0, err},    12'h000);
        cyc("sim_diff", 0, 1, 0, 1, 2, 0, 0);
        chk("sim_diff_cnt",  out_cnt,         12'h003);
        chk("sim_diff_cred", {8'h0, credits}, 12'h001);

        // underflow error is sticky, reset clears it
        cyc("uflow", 0, 0, 0, 1, 2, 0, 0);
        chk("uflow_err", {11'h0, err}, 12'h001);
        chk("uflow_cnt", out_cnt,      12'h003);
        idle("uflow_hold", 4);
        chk("uflow_sticky", {11'h0, err}, 12'h001);
        cyc("s1_req", 0, 1, 1, 0, 0, 0, 0);
        cyc("s1_req", 0, 1, 1, 0, 0, 0, 0);
        do_reset();
        chk("rst_cnt",  out_cnt,           12'h000);
        chk("rst_err",  {11'h0, err},      12'h000);
        chk("rst_cred", {8'h0, credits},   12'h004);
        chk("rst_stl",  {8'h0, rcn_stall}, 12'h000);

        // randomized traffic: mostly protocol-legal, with occasional chaos and reset
        for (int i = 0; i < 3000; i++) begin
            int k;
            k = int'($urandom_range(99));
            if (k < 1) begin
                do_reset();
            end else if (k < 6) begin
                cyc("rnd_chaos", 0, 1'($urandom_range(1)), int'($urandom_range(3)),
                    1'($urandom_range(1)), int'($urandom_range(3)),
                    1'($urandom_range(1)), int'($urandom_range(3)));
            end else begin
                st = exp_stall();
                qs = int'($urandom_range(3));
                q  = 1'($urandom_range(1)) && !st[qs];
                ps = int'($urandom_range(3));
                p  = 1'($urandom_range(1)) && (m_cnt[ps] > 0);
                fs = int'($urandom_range(3));
                f  = ($urandom_range(7) == 0);
                cyc("rnd", 0, q, qs, p, ps, f, fs);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tawas_rcn_stall_ctl.md
Name: tawas_rcn_stall_ctl

Overview:
- Tracks outstanding ring-bus (RCN) load/store transactions for each of the four Tawas slices.
- Drives the registered per-slice `rcn_stall[3:0]` vector consumed by the instruction fetch unit.
- Enforces a per-slice outstanding limit, a shared global credit pool, and per-slice fence waits (stall until all of that slice's transactions have completed).
- Sits between the load/store unit's bus issue/response path and fetch.

Parameters:
- MAX_OUT, 3, per-slice outstanding transaction limit; legal range 1..7.
- CREDITS, 4, shared ring-bus credit pool size; legal range 1..15.

Ports:
- clk  input  1  core clock
- rst  input  1  reset, synchronous, active-high
- req_vld  input  1  one RCN request issued this cycle
- req_slice  input  2  slice that issued the request
- rsp_vld  input  1  one RCN response retired this cycle
- rsp_slice  input  2  slice owning the response
- fence_vld  input  1  slice requests a wait until its outstanding count reaches 0
- fence_slice  input  2  slice issuing the fence
- rcn_stall  output  4  per-slice stall, bit n = slice n, registered
- out_cnt  output  12  per-slice outstanding counts {s3,s2,s1,s0}, 3 bits each, registered
- credits  output  4  free global credits, registered
- err  output  1  sticky protocol-error flag, registered

Behaviour:
- Reset (synchronous, active-high): all counts 0, credits = CREDITS, fence_pend[3:0] = 0, rcn_stall = 4'h0, err = 0. Reset asserted mid-traffic discards all tracking state; in-flight responses arriving after reset are treated as errors.
- Per-slice count update, each cycle:
  - inc = req_vld && req_slice==n; dec = rsp_vld && rsp_slice==n.
  - inc && !dec: cnt+1. dec && !inc: cnt-1. Both or neither: unchanged.
  - Saturation: cnt never exceeds 7 and never goes below 0.
- Global credits, each cycle:
  - req_vld only: credits-1. rsp_vld only: credits+1. Both: unchanged, even when the two slices differ.
  - Clamped to 0..CREDITS.
- Error conditions; each sets err, and err holds until rst:
  - dec when cnt==0 (count stays 0).
  - req when cnt==MAX_OUT (count still increments, up to 7).
  - req when credits==0 (credits stay 0).
  - rsp when credits==CREDITS.
- Fence per slice, a 2-state FSM:
  - IDLE -> WAIT on fence_vld for that slice, but only when the next-state cnt != 0. If the next-state cnt == 0, the fence completes immediately and the FSM stays IDLE.
  - WAIT -> IDLE when the next-state cnt == 0.
  - A fence_vld while already in WAIT is ignored.
- Stall equation, registered from next-state values:
  - rcn_stall[n] <= (cnt_next[n] >= MAX_OUT) || fence_next[n] || (credits_next == 0).
- Latency: an event in cycle T is visible on rcn_stall/out_cnt/credits in cycle T+1. Fetch samples rcn_stall[n] one cycle before slice n's fetch slot, so the block adds no extra pipeline delay.
- A stalled slice issues no new requests. Responses continue to drain while the slice is stalled.
- Exactly one req and one rsp can occur per cycle; no further arbitration is needed.

Test Plan:
- Reset, then idle 8 cycles -> rcn_stall=0, credits=4, out_cnt=0, err=0.
- Slice 1 issues 3 requests on consecutive cycles (req_slice=1) -> cnt1=3, rcn_stall=4'b0010 one cycle after the third req, credits=1. One rsp for slice 1 -> rcn_stall=0, cnt1=2.
- Slices 0,1,2,3 each issue one req -> credits=0, rcn_stall=4'hF. Then one rsp for slice 2 -> credits=1, rcn_stall=0.
- Slice 3 issues 2 reqs, then fence_vld slice 3 -> rcn_stall[3]=1 until the second rsp; deasserts the cycle after cnt3 reaches 0. A fence on slice 0 with cnt0=0 -> no stall ever asserted.
- Same-cycle req slice 0 and rsp slice 0 with cnt0=2 -> cnt0=2, credits unchanged, no err. Same-cycle req slice 0 and rsp slice 2 -> cnt0+1, cnt2-1, credits unchanged.
- rsp for slice 2 with cnt2=0 -> err=1 and stays 1; cnt2=0. Assert rst with cnt1=2 -> all state returns to reset values the next cycle, err=0.
